// File: rtl/rom_region_loader_if.sv
// Byte-in / word-out stream bundle for rom_region_loader.
// slave is the loader's view; master is the producer/consumer side.
interface rom_region_loader_if #(
  parameter int WORD_BYTES = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [3:0]              in_region;
  logic [31:0]             in_offset;
  logic [7:0]              in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [3:0]              out_storage;
  logic [31:0]             out_addr;
  logic [8*WORD_BYTES-1:0] out_data;
  logic [WORD_BYTES-1:0]   out_be;

  modport slave (
    input  in_valid, in_region, in_offset, in_data, in_last, out_ready,
    output in_ready, out_valid, out_storage, out_addr, out_data, out_be
  );

  modport master (
    output in_valid, in_region, in_offset, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_storage, out_addr, out_data, out_be
  );
endinterface

// File: rtl/rom_region_loader.sv
// ROM download router: packs (region, offset, byte) triples into byte-enabled
// words, relocates them through a region table and counts bytes per region.
package rom_region_loader_pkg;
  typedef enum logic [3:0] {
    STORAGE_SDR   = 4'd0,
    STORAGE_DDR   = 4'd1,
    STORAGE_BLOCK = 4'd2
  } region_storage_t;

  typedef enum logic [3:0] {
    ENCODING_NORMAL = 4'd0
  } region_encoding_t;

  typedef struct packed {
    logic [31:0]      base_addr;
    region_storage_t  storage;
    region_encoding_t encoding;
  } region_t;

  localparam region_t REGION_DEFAULT = '{
    base_addr: 32'h0,
    storage:   STORAGE_SDR,
    encoding:  ENCODING_NORMAL
  };
endpackage

module rom_region_loader
  import rom_region_loader_pkg::*;
#(
  parameter int                        NUM_REGIONS = 8,
  parameter int                        WORD_BYTES  = 2,
  parameter region_t [NUM_REGIONS-1:0] REGIONS     = {NUM_REGIONS{REGION_DEFAULT}},
  localparam int                       RW          = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  rom_region_loader_if.slave     bus,
  output logic                   err,
  input  logic [RW-1:0]          stat_region,
  output logic [31:0]            stat_bytes
);

  localparam int LW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  typedef struct packed {
    logic [RW-1:0]                region;
    logic [3:0]                   storage;
    logic [31:0]                  addr;
    logic [WORD_BYTES-1:0][7:0]   data;
    logic [WORD_BYTES-1:0]        be;
  } word_t;

  word_t                         acc_q, acc_d, out_q, merged, flush_word;
  logic                          acc_vld, acc_vld_d, out_vld;
  logic [NUM_REGIONS-1:0][31:0]  cnt_q;

  logic                          accept, region_ok, take, hit, switch_word, complete, flush;
  logic [RW-1:0]                 rsel;
  logic [LW-1:0]                 lane;
  logic [31:0]                   waddr;

  assign bus.in_ready    = !out_vld || bus.out_ready;
  assign bus.out_valid   = out_vld;
  assign bus.out_storage = out_q.storage;
  assign bus.out_addr    = out_q.addr;
  assign bus.out_data    = out_q.data;
  assign bus.out_be      = out_q.be;

  assign accept    = bus.in_valid && bus.in_ready;
  assign region_ok = 32'(bus.in_region) < NUM_REGIONS;
  // Out-of-table regions index entry 0 so the table lookup never goes out of range.
  assign rsel      = region_ok ? RW'(bus.in_region) : '0;
  assign lane      = LW'(bus.in_offset & 32'(WORD_BYTES - 1));
  assign waddr     = REGIONS[rsel].base_addr + (bus.in_offset & ~32'(WORD_BYTES - 1));
  assign take      = accept && region_ok;
  assign hit       = acc_vld && (acc_q.region == rsel) && (acc_q.addr == waddr);
  assign complete  = (lane == LW'(WORD_BYTES - 1)) || bus.in_last;

  // A word switch flushes the old accumulator; the new byte always stays behind,
  // so at most one word reaches the output register per cycle.
  assign switch_word = take && acc_vld && !hit;
  assign flush       = switch_word || (take && complete);

  always_comb begin
    merged = '0;
    if (hit) begin
      merged = acc_q;
    end else begin
      merged.region  = rsel;
      merged.storage = REGIONS[rsel].storage;
      merged.addr    = waddr;
    end
    merged.data[lane] = bus.in_data;
    merged.be[lane]   = 1'b1;

    flush_word = switch_word ? acc_q : merged;

    acc_d     = acc_q;
    acc_vld_d = acc_vld;
    if (take) begin
      acc_d     = merged;
      acc_vld_d = switch_word || !complete;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q   <= '0;
      acc_vld <= 1'b0;
      out_q   <= '0;
      out_vld <= 1'b0;
      err     <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      acc_vld <= acc_vld_d;
      if (flush) begin
        out_q   <= flush_word;
        out_vld <= 1'b1;
      end else if (bus.out_ready) begin
        out_vld <= 1'b0;
      end
      if (accept && !region_ok) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (take && (rsel == RW'(i)) && (cnt_q[i] != 32'hFFFF_FFFF))
          cnt_q[i] <= cnt_q[i] + 32'd1;
      end
    end
  end

  assign stat_bytes = (32'(stat_region) < NUM_REGIONS) ? cnt_q[stat_region] : 32'd0;

endmodule
